ksa_pg_input_stage: RTL

//  Registered pre-processing stage feeding the Kogge-Stone prefix tree (gray/black cells).

---
 rtl/ksa_pg_input_stage.sv | 140 ++++++++++++++
 1 files changed

// File: rtl/ksa_pg_input_stage.sv
// ---------------------------------------------------------------------------
// ksa_pg_input_stage
//
// Registered front end of a Kogge-Stone adder. Each accepted operand beat is
// turned into bitwise propagate (a^b) and generate (a&b), with the carry-in
// folded into bit 0's generate so that the prefix tree needs no separate
// carry-in path. A two-entry skid buffer (main register M, skid register S)
// sustains one beat per cycle while keeping in_ready a plain flop output.
// Accepted beats are also counted.
//
// Ports
//   clk        in   1      rising-edge clock
//   rst        in   1      synchronous active-high reset
//   in_valid   in   1      operand beat valid
//   in_ready   out  1      stage can accept an operand beat (registered)
//   in_a       in   WIDTH  operand A
//   in_b       in   WIDTH  operand B
//   in_cin     in   1      carry-in
//   out_valid  out  1      P/G beat valid to the prefix tree
//   out_ready  in   1      prefix tree accepts the beat
//   out_p      out  WIDTH  raw propagate A^B
//   out_g      out  WIDTH  generate A&B, bit 0 = a0&b0 | (a0^b0)&cin
//   out_cin    out  1      registered carry-in for the sum stage
//   op_count   out  CNT_W  accepted input beats, modulo 2^CNT_W
// ---------------------------------------------------------------------------
`timescale 1ns/1ps

module ksa_pg_input_stage #(
   parameter int WIDTH = 8,
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_a,
   input  logic [WIDTH-1:0] in_b,
   input  logic             in_cin,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_p,
   output logic [WIDTH-1:0] out_g,
   output logic             out_cin,
   output logic [CNT_W-1:0] op_count
);

   typedef struct packed {
      logic [WIDTH-1:0] p;
      logic [WIDTH-1:0] g;
      logic             cin;
   } beat_t;

   beat_t            r_m;
   beat_t            r_s;
   logic             r_m_valid;
   logic             r_s_valid;
   logic             r_in_ready;
   logic [CNT_W-1:0] r_op_count;

   beat_t w_new;
   beat_t w_m_nxt;
   beat_t w_s_nxt;
   logic  w_m_valid_nxt;
   logic  w_s_valid_nxt;
   logic  w_acc;
   logic  w_xfer;

   assign w_acc  = in_valid & r_in_ready;
   assign w_xfer = r_m_valid & out_ready;

   // P/G of the incoming operands; bit 0 generate absorbs the carry-in.
   always_comb begin
      w_new.p    = in_a ^ in_b;
      w_new.g    = in_a & in_b;
      w_new.g[0] = (in_a[0] & in_b[0]) | ((in_a[0] ^ in_b[0]) & in_cin);
      w_new.cin  = in_cin;
   end

   // Skid-buffer steering. S is only ever filled while M is stalled, and
   // while S holds a beat in_ready is low, so acc and a full S never coincide.
   always_comb begin
      // NOTE: hold-current-value defaults first, so every path assigns every
      // signal and no latch is inferred.
      w_m_nxt       = r_m;
      w_s_nxt       = r_s;
      w_m_valid_nxt = r_m_valid;
      w_s_valid_nxt = r_s_valid;
      if (r_s_valid) begin
         if (w_xfer) begin
            w_m_nxt       = r_s;
            w_s_valid_nxt = 1'b0;
         end
      end else if (!r_m_valid || w_xfer) begin
         if (w_acc) begin
            w_m_nxt       = w_new;
            w_m_valid_nxt = 1'b1;
         end else if (w_xfer) begin
            w_m_valid_nxt = 1'b0;
         end
      end else if (w_acc) begin
         w_s_nxt       = w_new;
         w_s_valid_nxt = 1'b1;
      end
   end

   // NOTE: state registers use non-blocking assignments so every flop
   // samples the pre-edge values regardless of statement order.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_m          <= '0;
         r_m_valid    <= 1'b0;
         r_s_valid    <= 1'b0;
         r_in_ready   <= 1'b1;
         r_op_count   <= '0;
      end else begin
         r_m          <= w_m_nxt;
         r_m_valid    <= w_m_valid_nxt;
         r_s_valid    <= w_s_valid_nxt;
         // in_ready mirrors the next skid state so it comes straight off a flop.
         r_in_ready   <= ~w_s_valid_nxt;
         if (w_acc) begin
            r_op_count <= r_op_count + 1'b1;
         end
      end
   end

   // NOTE: skid data is not reset; it is never observed unless r_s_valid is
   // set, and that bit is reset. M data is reset because it drives out_*.
   always_ff @(posedge clk) begin
      r_s <= w_s_nxt;
   end

   assign in_ready  = r_in_ready;
   assign out_valid = r_m_valid;
   assign out_p     = r_m.p;
   assign out_g     = r_m.g;
   assign out_cin   = r_m.cin;
   assign op_count  = r_op_count;

endmodule
